// File: rtl/wb_tia_audio.sv
// Wishbone TIA-style multi-channel audio generator with per-channel poly/divider tones and summing mixer.
// Optional PWM output stage enabled by defining WB_TIA_AUDIO_PWM_EN; otherwise pwm_o is tied low.
module wb_tia_audio #(
  parameter int WB_DATA_WIDTH = 8,
  parameter int WB_ADDR_WIDTH = 4,
  parameter int NUM_CH        = 2,
  parameter int CLK_DIV       = 512,
  localparam int MIX_W        = 4 + $clog2(NUM_CH)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     stb_i,
  input  logic                     we_i,
  input  logic [WB_ADDR_WIDTH-1:0] adr_i,
  input  logic [WB_DATA_WIDTH-1:0] dat_i,
  output logic                     ack_o,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  output logic [MIX_W-1:0]         mix_o,
  output logic                     pwm_o
);

  localparam int CW = WB_ADDR_WIDTH - 2;
  localparam int PW = $clog2(CLK_DIV);

  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic [CW-1:0] ch_sel;
  logic [1:0]    reg_sel;
  logic          wr_en;
  logic          unused_dat;

  logic [4:0]               ch_rd  [NUM_CH];
  logic [3:0]               ch_vol [NUM_CH];
  logic [WB_DATA_WIDTH-1:0] rd_data;
  logic [MIX_W-1:0]         mix_sum;

  assign ch_sel     = adr_i[WB_ADDR_WIDTH-1:2];
  assign reg_sel    = adr_i[1:0];
  assign wr_en      = stb_i && we_i;
  assign unused_dat = ^dat_i;
  assign tick       = (pre_cnt == PW'(CLK_DIV - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + PW'(1);
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic       sel;
    logic [3:0] audc;
    logic [4:0] audf;
    logic [3:0] audv;
    logic [4:0] fcnt;
    logic       pulse;
    logic [3:0] poly4;
    logic [4:0] poly5;
    logic [8:0] poly9;
    logic [4:0] div31;
    logic [1:0] div6;
    logic       tog6;
    logic       tog2;
    logic       poly4_adv;
    logic       div6_adv;
    logic       ch_bit;
    logic [4:0] rd_val;

    assign sel       = wr_en && (ch_sel == CW'(c));
    assign pulse     = tick && (fcnt == audf);
    assign poly4_adv = (audc == 4'h2 || audc == 4'h3) ? poly5[4] : 1'b1;
    assign div6_adv  = (audc == 4'hF) ? poly5[4] : 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        audc <= '0;
        audf <= '0;
        audv <= '0;
      end else if (sel) begin
        case (reg_sel)
          2'd0:    audc <= dat_i[3:0];
          2'd1:    audf <= dat_i[4:0];
          2'd2:    audv <= dat_i[3:0];
          default: ;
        endcase
      end
    end

    // Generators step on the old register values when a write lands on a pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        fcnt  <= '0;
        poly4 <= '1;
        poly5 <= '1;
        poly9 <= '1;
        div31 <= '0;
        div6  <= '0;
        tog6  <= 1'b0;
        tog2  <= 1'b0;
      end else begin
        if (tick) fcnt <= pulse ? 5'd0 : fcnt + 5'd1;
        if (pulse) begin
          if (poly4_adv) poly4 <= (poly4 == '0) ? '1 : {poly4[2:0], poly4[3] ^ poly4[2]};
          poly5 <= (poly5 == '0) ? '1 : {poly5[3:0], poly5[4] ^ poly5[2]};
          poly9 <= (poly9 == '0) ? '1 : {poly9[7:0], poly9[8] ^ poly9[4]};
          div31 <= (div31 == 5'd30) ? 5'd0 : div31 + 5'd1;
          tog2  <= ~tog2;
          if (div6_adv) begin
            if (div6 == 2'd2) begin
              div6 <= 2'd0;
              tog6 <= ~tog6;
            end else begin
              div6 <= div6 + 2'd1;
            end
          end
        end
      end
    end

    always_comb begin
      ch_bit = 1'b1;
      case (audc)
        4'h0, 4'hB:       ch_bit = 1'b1;
        4'h1, 4'h2, 4'h3: ch_bit = poly4[3];
        4'h4, 4'h5:       ch_bit = tog2;
        4'h6, 4'hA:       ch_bit = (div31 < 5'd13);
        4'h7, 4'h9:       ch_bit = poly5[4];
        4'h8:             ch_bit = poly9[8];
        default:          ch_bit = tog6;
      endcase
    end

    always_comb begin
      rd_val = '0;
      case (reg_sel)
        2'd0:    rd_val = {1'b0, audc};
        2'd1:    rd_val = audf;
        2'd2:    rd_val = {1'b0, audv};
        default: rd_val = {4'b0, ch_bit};
      endcase
    end

    assign ch_rd[c]  = rd_val;
    assign ch_vol[c] = ch_bit ? audv : 4'd0;
  end

  // Unpopulated channel slots fall through to zero.
  always_comb begin
    rd_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_sel == CW'(c)) rd_data[4:0] = ch_rd[c];
    end
  end

  always_comb begin
    mix_sum = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      mix_sum = mix_sum + MIX_W'(ch_vol[c]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_o <= 1'b0;
      dat_o <= '0;
      mix_o <= '0;
    end else begin
      ack_o <= stb_i;
      if (stb_i && !we_i) dat_o <= rd_data;
      mix_o <= mix_sum;
    end
  end

`ifdef WB_TIA_AUDIO_PWM_EN
  logic [MIX_W-1:0] pwm_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pwm_cnt <= '0;
      pwm_o   <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + MIX_W'(1);
      pwm_o   <= (pwm_cnt < mix_o);
    end
  end
`else
  assign pwm_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_tia_audio.sv
// Bench for wb_tia_audio: directed and random bus traffic against a pulse-count based reference model.
module tb_wb_tia_audio;
  localparam int DW = 8, AW = 4, NCH = 2, CDIV = 4, MW = 5;

  logic          clk_i = 1'b0, rst_ni = 1'b0, stb_i = 1'b0, we_i = 1'b0;
  logic [AW-1:0] adr_i = '0;
  logic [DW-1:0] dat_i = '0;
  logic          ack_o;
  logic [DW-1:0] dat_o;
  logic [MW-1:0] mix_o;
  logic          pwm_o;

  int n_checks = 0, n_fail = 0;

  wb_tia_audio #(.WB_DATA_WIDTH(DW), .WB_ADDR_WIDTH(AW), .NUM_CH(NCH), .CLK_DIV(CDIV)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .stb_i(stb_i), .we_i(we_i), .adr_i(adr_i),
    .dat_i(dat_i), .ack_o(ack_o), .dat_o(dat_o), .mix_o(mix_o), .pwm_o(pwm_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Polynomial output sequences indexed by number of advances from the all-ones seed.
  bit p4[15];
  bit p5[31];
  bit p9[511];

  int m_pre;
  int m_fcnt[NCH], m_audc[NCH], m_audf[NCH], m_audv[NCH];
  int m_i4[NCH], m_i5[NCH], m_i9[NCH], m_n31[NCH], m_n2[NCH], m_n6[NCH];
  int e_mix, e_dat, e_ack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic void build_seqs();
    int s;
    s = 15;
    for (int k = 0; k < 15; k++) begin
      p4[k] = s[3];
      s = ((s << 1) | int'(s[3] ^ s[2])) & 15;
    end
    s = 31;
    for (int k = 0; k < 31; k++) begin
      p5[k] = s[4];
      s = ((s << 1) | int'(s[4] ^ s[2])) & 31;
    end
    s = 511;
    for (int k = 0; k < 511; k++) begin
      p9[k] = s[8];
      s = ((s << 1) | int'(s[8] ^ s[4])) & 511;
    end
  endfunction

  function automatic void m_reset();
    m_pre = 0;
    for (int c = 0; c < NCH; c++) begin
      m_fcnt[c] = 0; m_audc[c] = 0; m_audf[c] = 0; m_audv[c] = 0;
      m_i4[c] = 0; m_i5[c] = 0; m_i9[c] = 0; m_n31[c] = 0; m_n2[c] = 0; m_n6[c] = 0;
    end
    e_mix = 0; e_dat = 0; e_ack = 0;
  endfunction

  function automatic bit mbit(int c);
    case (m_audc[c])
      0, 11:   return 1'b1;
      1, 2, 3: return p4[m_i4[c]];
      4, 5:    return m_n2[c] == 1;
      6, 10:   return m_n31[c] < 13;
      7, 9:    return p5[m_i5[c]];
      8:       return p9[m_i9[c]];
      default: return m_n6[c] >= 3;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  function automatic void model_step();
    bit b[NCH];
    int sum, ch, rg;
    bit tick, pulse, a4, a6;
    sum = 0;
    for (int c = 0; c < NCH; c++) begin
      b[c] = mbit(c);
      if (b[c]) sum += m_audv[c];
    end
    ch = int'(adr_i[AW-1:2]);
    rg = int'(adr_i[1:0]);
    e_ack = int'(stb_i);
    if (stb_i && !we_i) begin
      if (ch >= NCH) e_dat = 0;
      else case (rg)
        0:       e_dat = m_audc[ch];
        1:       e_dat = m_audf[ch];
        2:       e_dat = m_audv[ch];
        default: e_dat = int'(b[ch]);
      endcase
    end
    tick = (m_pre == CDIV - 1);
    m_pre = tick ? 0 : m_pre + 1;
    for (int c = 0; c < NCH; c++) begin
      pulse = tick && (m_fcnt[c] == m_audf[c]);
      if (tick) m_fcnt[c] = pulse ? 0 : (m_fcnt[c] + 1) % 32;
      if (pulse) begin
        a4 = !(m_audc[c] == 2 || m_audc[c] == 3) || p5[m_i5[c]];
        a6 = (m_audc[c] != 15) || p5[m_i5[c]];
        if (a4) m_i4[c] = (m_i4[c] + 1) % 15;
        if (a6) m_n6[c] = (m_n6[c] + 1) % 6;
        m_i5[c]  = (m_i5[c] + 1) % 31;
        m_i9[c]  = (m_i9[c] + 1) % 511;
        m_n31[c] = (m_n31[c] + 1) % 31;
        m_n2[c]  = (m_n2[c] + 1) % 2;
      end
    end
    if (stb_i && we_i && ch < NCH) begin
      case (rg)
        0: m_audc[ch] = int'(dat_i) & 15;
        1: m_audf[ch] = int'(dat_i) & 31;
        2: m_audv[ch] = int'(dat_i) & 15;
        default: ;
      endcase
    end
    e_mix = sum;
  endfunction

  task automatic cycle();
    model_step();
    @(posedge clk_i);
    #1;
    chk("ack", {31'b0, ack_o}, e_ack);
    chk("dat", {24'b0, dat_o}, e_dat);
    chk("mix", {27'b0, mix_o}, e_mix);
`ifndef WB_TIA_AUDIO_PWM_EN
    chk("pwm_off", {31'b0, pwm_o}, 0);
`endif
  endtask

  task automatic wr(input int ch, input int rg, input int d);
    stb_i = 1'b1; we_i = 1'b1; adr_i = AW'(ch * 4 + rg); dat_i = DW'(d);
    cycle();
    stb_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic rd(input int ch, input int rg);
    stb_i = 1'b1; we_i = 1'b0; adr_i = AW'(ch * 4 + rg);
    cycle();
    stb_i = 1'b0;
  endtask

  task automatic rd_loop(input int ch, input int rg, input int n);
    for (int i = 0; i < n; i++) rd(ch, rg);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int modes[14] = '{1, 2, 3, 6, 7, 9, 8, 12, 15, 10, 11, 5, 13, 14};
    int found, cnt;
    build_seqs();
    m_reset();

    @(posedge clk_i);
    #1;
    chk("rst_ack", {31'b0, ack_o}, 0);
    chk("rst_dat", {24'b0, dat_o}, 0);
    chk("rst_mix", {27'b0, mix_o}, 0);
    chk("rst_pwm", {31'b0, pwm_o}, 0);
    rst_ni = 1'b1;

    rd(0, 0);
    chk("rd_audc0_after_rst", {24'b0, dat_o}, 0);

    // div2 square wave, fast then slow
    wr(0, 0, 4); wr(0, 1, 0); wr(0, 2, 15);
    idle(40);
    wr(0, 1, 3);
    idle(70);

    // constant-high channels summed
    wr(0, 0, 0); wr(1, 0, 0); wr(0, 2, 15); wr(1, 2, 9);
    cycle();
    chk("mix_sum24", {27'b0, mix_o}, 24);

    // poly4 and poly9 noise
    wr(0, 0, 1); wr(0, 1, 0);
    rd_loop(0, 3, 15 * CDIV * 3);
    wr(0, 0, 8);
    rd_loop(0, 3, 600);

    foreach (modes[i]) begin
      wr(0, 0, modes[i]); wr(0, 1, i % 3);
      wr(1, 0, modes[13 - i]); wr(1, 1, 0);
      rd_loop(0, 3, 80);
      rd_loop(1, 3, 80);
    end

    // AUDF lowered below current fcnt: counter wraps through 31
    wr(0, 0, 4); wr(0, 1, 20);
    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      if (m_fcnt[0] == 10) found = 1;
      else cycle();
    end
    chk("fcnt_reach_10", found, 1);
    wr(0, 1, 2);
    rd_loop(0, 3, 40 * CDIV);
    rd(0, 1);
    chk("audf0_readback", {24'b0, dat_o}, 2);

    // unpopulated channel 3
    wr(3, 0, 5); wr(3, 1, 7); wr(3, 2, 9);
    rd(3, 0); rd(3, 1); rd(3, 2); rd(3, 3);
    chk("ch3_read_zero", {24'b0, dat_o}, 0);

    for (int i = 0; i < 400; i++) begin
      stb_i = 1'($urandom_range(0, 1));
      we_i  = ($urandom_range(0, 3) == 0);
      adr_i = AW'($urandom_range(0, 15));
      dat_i = DW'($urandom);
      cycle();
    end
    stb_i = 1'b0; we_i = 1'b0;

`ifdef WB_TIA_AUDIO_PWM_EN
    wr(0, 0, 0); wr(0, 2, 15); wr(1, 2, 0);
    idle(3);
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      cycle();
      if (pwm_o) cnt++;
    end
    chk("pwm_duty15", cnt, 15);
`endif

    // asynchronous reset with a read in flight
    wr(0, 0, 0); wr(0, 2, 7); rd(0, 2);
    stb_i = 1'b1; we_i = 1'b0; adr_i = AW'(2);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_ack", {31'b0, ack_o}, 0);
    chk("arst_dat", {24'b0, dat_o}, 0);
    chk("arst_mix", {27'b0, mix_o}, 0);
    chk("arst_pwm", {31'b0, pwm_o}, 0);
    m_reset();
    @(posedge clk_i);
    #1;
    chk("arst_no_ack", {31'b0, ack_o}, 0);
    rst_ni = 1'b1;
    stb_i = 1'b0;
    cycle();
    rd(0, 0);
    chk("arst_rd_ack", {31'b0, ack_o}, 1);
    chk("arst_rd_audc0", {24'b0, dat_o}, 0);
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
